nbit_restoring_divider: RTL and testbench

- Sequential N-bit unsigned restoring divider; the inverse of the team's N-bit array multiplier.
- Performs one shift/subtract/restore iteration per clock and produces a quotient and remainder after N iterations.
- Sits beside the multiplier array as the arithmetic unit's divide path.
- Uses a start/busy/done handshake so a controller or bench can sequence operations.

---
 rtl/nbit_restoring_divider.sv | 104 ++++++++++
 tb/tb_nbit_restoring_divider.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nbit_restoring_divider.sv
// Sequential unsigned restoring divider: one shift/subtract/restore step per clock,
// start/busy/done handshake, quotient and remainder held until the next result.
module nbit_restoring_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         divByZero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t        stateReg, stateNext;
  logic [N-1:0]  qReg, qNext;
  logic [N-1:0]  dReg, dNext;
  logic [N:0]    rReg, rNext;
  logic [CW-1:0] cntReg, cntNext;
  logic          dbzReg, dbzNext;
  logic [N-1:0]  quotientNext, remainderNext;
  logic          doneNext, divByZeroNext;
  logic [N:0]    rShift, trial;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg  <= IDLE;
      qReg      <= '0;
      dReg      <= '0;
      rReg      <= '0;
      cntReg    <= '0;
      dbzReg    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
      divByZero <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      qReg      <= qNext;
      dReg      <= dNext;
      rReg      <= rNext;
      cntReg    <= cntNext;
      dbzReg    <= dbzNext;
      quotient  <= quotientNext;
      remainder <= remainderNext;
      done      <= doneNext;
      divByZero <= divByZeroNext;
    end
  end

  // Partial remainder stays below the divisor, so its top bit is always 0 before the shift.
  assign rShift = {rReg[N-1:0], qReg[N-1]};
  assign trial  = rShift - {1'b0, dReg};
  assign busy   = (stateReg != IDLE);

  always_comb begin
    stateNext     = stateReg;
    qNext         = qReg;
    dNext         = dReg;
    rNext         = rReg;
    cntNext       = cntReg;
    dbzNext       = dbzReg;
    quotientNext  = quotient;
    remainderNext = remainder;
    divByZeroNext = divByZero;
    doneNext      = 1'b0;

    case (stateReg)
      IDLE: begin
        if (start) begin
          qNext     = dividend;
          dNext     = divisor;
          rNext     = '0;
          cntNext   = '0;
          dbzNext   = (divisor == '0);
          stateNext = (divisor == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        qNext   = {qReg[N-2:0], ~trial[N]};
        rNext   = trial[N] ? rShift : trial;
        cntNext = cntReg + 1'b1;
        if (cntReg == CW'(N - 1)) stateNext = FIN;
      end
      FIN: begin
        // On divide-by-zero the Q register still holds the untouched dividend.
        quotientNext  = dbzReg ? '1 : qReg;
        remainderNext = dbzReg ? qReg : rReg[N-1:0];
        divByZeroNext = dbzReg;
        doneNext      = 1'b1;
        stateNext     = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nbit_restoring_divider.sv
// Directed bench for the restoring divider: latency, back-to-back, divide-by-zero,
// ignored start, async reset abort and a short operand sweep.
module tb_nbit_restoring_divider;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic [N-1:0] quotient, remainder;
  logic         busy, done, divByZero;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  int acceptCycle = 0;

  nbit_restoring_divider #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .divByZero(divByZero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic startOp(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    acceptCycle = cycleCnt;
  endtask

  task automatic waitDone(output int doneCycle, output int busyCycles);
    int n = 0;
    bit seen = 0;
    busyCycles = 0;
    while (n < 40) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) busyCycles++;
      @(negedge clk);
      n++;
    end
    doneCycle = cycleCnt;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: no done within 40 cycles, required done=1");
    end
  endtask

  task automatic countDones(input int cycles, output int dones);
    dones = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({quotient, remainder, busy, done, divByZero} !== '0) begin
      errors++;
      $display("FAIL reset_state: q=%0d r=%0d busy=%b done=%b dbz=%b, required all 0",
               quotient, remainder, busy, done, divByZero);
    end
    @(negedge clk);
    reset = 1'b0;
    $display("reset: q=%0d r=%0d busy=%b", quotient, remainder, busy);
  endtask

  task automatic test_normal;
    int dc, bc;
    startOp(8'd100, 8'd7);
    waitDone(dc, bc);
    checks++;
    if (dc - acceptCycle !== 9) begin
      errors++;
      $display("FAIL normal_latency: got %0d, required 9", dc - acceptCycle);
    end
    checks++;
    if (bc !== 9) begin
      errors++;
      $display("FAIL normal_busy_cycles: got %0d, required 9", bc);
    end
    checks++;
    if (quotient !== 8'd14 || remainder !== 8'd2 || divByZero !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL normal_result: q=%0d r=%0d dbz=%b busy=%b, required 14 2 0 0",
               quotient, remainder, divByZero, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: done=%b one cycle later, required 0", done);
    end
    $display("100/7 -> q=%0d r=%0d latency=%0d", quotient, remainder, dc - acceptCycle);
  endtask

  task automatic test_back_to_back;
    int d1, d2, bc;
    startOp(8'd255, 8'd1);
    waitDone(d1, bc);
    checks++;
    if (quotient !== 8'd255 || remainder !== 8'd0) begin
      errors++;
      $display("FAIL b2b_first: q=%0d r=%0d, required 255 0", quotient, remainder);
    end
    dividend = 8'd5;
    divisor  = 8'd9;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || quotient !== 8'd255 || remainder !== 8'd0) begin
      errors++;
      $display("FAIL b2b_hold: busy=%b q=%0d r=%0d, required 1 255 0", busy, quotient, remainder);
    end
    waitDone(d2, bc);
    checks++;
    if (d2 - d1 !== N + 2) begin
      errors++;
      $display("FAIL b2b_interval: got %0d, required %0d", d2 - d1, N + 2);
    end
    checks++;
    if (quotient !== 8'd0 || remainder !== 8'd5) begin
      errors++;
      $display("FAIL b2b_second: q=%0d r=%0d, required 0 5", quotient, remainder);
    end
    $display("255/1 then 5/9 -> q=%0d r=%0d interval=%0d", quotient, remainder, d2 - d1);
  endtask

  task automatic test_div_by_zero;
    int dc, bc;
    startOp(8'd77, 8'd0);
    waitDone(dc, bc);
    checks++;
    if (dc - acceptCycle !== 1) begin
      errors++;
      $display("FAIL dbz_latency: got %0d, required 1", dc - acceptCycle);
    end
    checks++;
    if (quotient !== 8'd255 || remainder !== 8'd77 || divByZero !== 1'b1) begin
      errors++;
      $display("FAIL dbz_result: q=%0d r=%0d dbz=%b, required 255 77 1", quotient, remainder, divByZero);
    end
    startOp(8'd9, 8'd3);
    checks++;
    if (divByZero !== 1'b1) begin
      errors++;
      $display("FAIL dbz_hold: dbz=%b while running, required 1", divByZero);
    end
    waitDone(dc, bc);
    checks++;
    if (quotient !== 8'd3 || remainder !== 8'd0 || divByZero !== 1'b0) begin
      errors++;
      $display("FAIL dbz_clear: q=%0d r=%0d dbz=%b, required 3 0 0", quotient, remainder, divByZero);
    end
    $display("77/0 then 9/3 -> q=%0d r=%0d dbz=%b", quotient, remainder, divByZero);
  endtask

  task automatic test_start_ignored;
    int dc, bc, extra;
    startOp(8'd200, 8'd3);
    repeat (3) @(negedge clk);
    dividend = 8'd10;
    divisor  = 8'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(dc, bc);
    checks++;
    if (dc - acceptCycle !== 9 || quotient !== 8'd66 || remainder !== 8'd2) begin
      errors++;
      $display("FAIL run_start_ignored: lat=%0d q=%0d r=%0d, required 9 66 2",
               dc - acceptCycle, quotient, remainder);
    end
    countDones(15, extra);
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL run_extra_done: got %0d extra done pulses, required 0", extra);
    end
    $display("200/3 with 10/2 pulsed -> q=%0d r=%0d", quotient, remainder);
  endtask

  task automatic test_reset_abort;
    int dc, bc, extra;
    startOp(8'd250, 8'd6);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({quotient, remainder, busy, done, divByZero} !== '0) begin
      errors++;
      $display("FAIL async_reset: q=%0d r=%0d busy=%b done=%b dbz=%b, required all 0",
               quotient, remainder, busy, done, divByZero);
    end
    @(negedge clk);
    reset = 1'b0;
    countDones(15, extra);
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL abort_done: got %0d done pulses, required 0", extra);
    end
    startOp(8'd250, 8'd6);
    waitDone(dc, bc);
    checks++;
    if (quotient !== 8'd41 || remainder !== 8'd4) begin
      errors++;
      $display("FAIL after_abort: q=%0d r=%0d, required 41 4", quotient, remainder);
    end
    $display("250/6 after abort -> q=%0d r=%0d", quotient, remainder);
  endtask

  task automatic test_sweep;
    int dc, bc;
    logic [N-1:0] a, b;
    logic [7:0] edgeA [6] = '{8'd255, 8'd0, 8'd1, 8'd254, 8'd128, 8'd255};
    logic [7:0] edgeB [6] = '{8'd255, 8'd5, 8'd255, 8'd255, 8'd1, 8'd2};
    for (int i = 0; i < 200; i++) begin
      if (i < 6) begin
        a = edgeA[i];
        b = edgeB[i];
      end else begin
        a = N'($urandom_range(0, 255));
        b = N'($urandom_range(1, 255));
      end
      startOp(a, b);
      waitDone(dc, bc);
      checks++;
      if (quotient !== a / b || remainder !== a % b ||
          16'(quotient) * 16'(b) + 16'(remainder) !== 16'(a) || !(remainder < b)) begin
        errors++;
        $display("FAIL sweep %0d/%0d: q=%0d r=%0d, required %0d %0d", a, b, quotient, remainder,
                 a / b, a % b);
      end else begin
        $display("sweep %0d/%0d -> q=%0d r=%0d", a, b, quotient, remainder);
      end
    end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_back_to_back;
    test_div_by_zero;
    test_start_ignored;
    test_reset_abort;
    test_sweep;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
